// File: rtl/sseg_sched.sv
// ---------------------------------------------------------------------------
// SsegSched (module sseg_sched)
//
// Rotates a set of 64-bit seven-segment "pages" toward a single display
// driver. Each source owns one page slot it may rewrite at any time; the
// scheduler shows each valid page for DWELL_CYC cycles, then moves on to the
// next valid page in round-robin order. A rewrite of the page on screen is
// pushed to the driver straight away.
//
// Ports
//   clk       - sole clock, rising edge
//   rst_n     - asynchronous active-low reset
//   src_data  - NUM_SRC x 64-bit page data, slice i belongs to source i
//   src_vld   - per-source page-write request
//   src_rdy   - per-source write accept (low only for the page being loaded)
//   hold      - freezes rotation on the current page
//   out_data  - page presented to the display driver (byte 0 = digit 0)
//   out_vld   - out_data valid toward the driver
//   out_rdy   - driver ready / idle
//   cur_sel   - index of the page currently selected
// ---------------------------------------------------------------------------
module sseg_sched #(
  parameter int NUM_SRC   = 4,
  parameter int DWELL_CYC = 100_000_000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_SRC*64-1:0]      src_data,
  input  logic [NUM_SRC-1:0]         src_vld,
  output logic [NUM_SRC-1:0]         src_rdy,
  input  logic                       hold,
  output logic [63:0]                out_data,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [$clog2(NUM_SRC)-1:0] cur_sel
);

  localparam int SEL_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(DWELL_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DWELL = 2'd2;
  localparam logic [1:0] NEXT  = 2'd3;

  logic [1:0]       r_state;
  logic [63:0]      r_page [NUM_SRC];
  logic [NUM_SRC-1:0] r_pg_vld;
  logic [NUM_SRC-1:0] r_dirty;
  logic [SEL_W-1:0] r_cur_sel;
  logic [63:0]      r_out_data;
  logic [CNT_W-1:0] r_cnt;

  logic [NUM_SRC-1:0] w_accept;
  logic [SEL_W-1:0]   w_low_idx;
  logic [SEL_W-1:0]   w_nxt_idx;
  logic               w_any_vld;
  logic               w_load_done;

  assign out_vld     = (r_state == LOAD);
  assign out_data    = r_out_data;
  assign cur_sel     = r_cur_sel;
  assign w_accept    = src_vld & src_rdy;
  assign w_any_vld   = |r_pg_vld;
  assign w_load_done = (r_state == LOAD) && out_rdy;

  // Only the page being pushed to the driver is write-protected, so the
  // driver never sees a page change underneath an open transfer.
  always_comb begin
    src_rdy = '1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if ((r_state == LOAD) && (r_cur_sel == SEL_W'(i))) begin
        src_rdy[i] = 1'b0;
      end
    end
  end

  // Lowest valid page, used when leaving IDLE. Scanning downward lets the
  // smallest index win.
  always_comb begin
    w_low_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r_pg_vld[i]) begin
        w_low_idx = SEL_W'(i);
      end
    end
  end

  // Round-robin successor: first valid page after cur_sel, wrapping all the
  // way round so the current page itself is the last candidate.
  always_comb begin
    int j;
    j         = 0;
    w_nxt_idx = r_cur_sel;
    for (int k = NUM_SRC; k >= 1; k--) begin
      j = (int'(r_cur_sel) + k) % NUM_SRC;
      if (r_pg_vld[j]) begin
        w_nxt_idx = SEL_W'(j);
      end
    end
  end

  // Page storage. Every source is independent, so simultaneous writes all
  // land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_page[i] <= '0;
      end
      r_pg_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) begin
          r_page[i]   <= src_data[i*64 +: 64];
          r_pg_vld[i] <= 1'b1;
        end
      end
    end
  end

  // Dirty flags mark pages whose latest contents have not yet reached the
  // driver. The clear and a new write can never hit the same slot in one
  // cycle because that slot is not ready while it is being loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= '0;
    end else begin
      if (w_load_done) begin
        r_dirty[r_cur_sel] <= 1'b0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_accept[i]) begin
          r_dirty[i] <= 1'b1;
        end
      end
    end
  end

  // Scheduler FSM. A refresh of the page on screen beats both hold and dwell
  // expiry, and keeps the dwell count so a rewrite does not extend the
  // page's time on screen beyond the extra reload cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cur_sel  <= '0;
      r_out_data <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_vld) begin
            r_cur_sel  <= w_low_idx;
            r_out_data <= r_page[w_low_idx];
            r_cnt      <= '0;
            r_state    <= LOAD;
          end
        end
        LOAD: begin
          if (out_rdy) begin
            r_state <= DWELL;
          end
        end
        DWELL: begin
          if (r_dirty[r_cur_sel]) begin
            r_out_data <= r_page[r_cur_sel];
            r_state    <= LOAD;
          end else if (!hold) begin
            if (r_cnt == CNT_LAST) begin
              r_cnt   <= '0;
              r_state <= NEXT;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        NEXT: begin
          if ((w_nxt_idx != r_cur_sel) || r_dirty[w_nxt_idx]) begin
            r_cur_sel  <= w_nxt_idx;
            r_out_data <= r_page[w_nxt_idx];
            r_state    <= LOAD;
          end else begin
            r_state <= DWELL;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sseg_sched.sv
// ---------------------------------------------------------------------------
// tb_sseg_sched
//
// Self-checking bench for sseg_sched with NUM_SRC=4, DWELL_CYC=8. Page data
// is random; expected rotation order, transfer timing and data come from a
// small page-level model (array of pages, valid mask, round-robin rule and
// the cycle budget of dwell + next + load).
// ---------------------------------------------------------------------------
module tb_sseg_sched;

  localparam int NS = 4;
  localparam int DW = 8;
  localparam int PERIOD = DW + 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NS*64-1:0] src_data;
  logic [NS-1:0]   src_vld;
  logic [NS-1:0]   src_rdy;
  logic            hold;
  logic [63:0]     out_data;
  logic            out_vld;
  logic            out_rdy;
  logic [1:0]      cur_sel;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int          xEdge[$];
  int          xSel[$];
  logic [63:0] xData[$];
  int          vldHigh = 0;

  logic [63:0] modelPage [NS];

  sseg_sched #(.NUM_SRC(NS), .DWELL_CYC(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_data (src_data),
    .src_vld  (src_vld),
    .src_rdy  (src_rdy),
    .hold     (hold),
    .out_data (out_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .cur_sel  (cur_sel)
  );

  always #5 clk = ~clk;

  // Edge counter: at a falling edge, cyc equals the number of rising edges
  // seen so far, so a transfer observed there completes at edge cyc+1.
  always @(posedge clk) cyc <= cyc + 1;

  // Transfer log of every driver handshake, plus a count of out_vld cycles.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      xEdge.push_back(cyc + 1);
      xSel.push_back(int'(cur_sel));
      xData.push_back(out_data);
    end
    if (out_vld) vldHigh++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic int lowestIdx(logic [NS-1:0] mask);
    for (int i = 0; i < NS; i++) if (mask[i]) return i;
    return 0;
  endfunction

  function automatic int nextValid(int cur, logic [NS-1:0] mask);
    for (int k = 1; k <= NS; k++) begin
      if (mask[(cur + k) % NS]) return (cur + k) % NS;
    end
    return cur;
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitCyc(int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clearLog();
    xEdge.delete();
    xSel.delete();
    xData.delete();
    vldHigh = 0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n   = 1'b0;
    src_vld = '0;
    hold    = 1'b0;
    out_rdy = 1'b1;
    for (int i = 0; i < NS; i++) modelPage[i] = '0;
    tick(2);
    clearLog();
    rst_n = 1'b1;
    tick(1);
  endtask

  // Presents one write cycle on the sources in mask with fresh random data;
  // e0 is the rising edge that carries the handshake.
  task automatic applyStimulus(input logic [NS-1:0] mask, output int e0);
    for (int i = 0; i < NS; i++) begin
      if (mask[i]) begin
        modelPage[i] = rnd64();
        src_data[i*64 +: 64] = modelPage[i];
      end
    end
    src_vld = mask;
    e0 = cyc + 1;
    tick(1);
    src_vld = '0;
  endtask

  task automatic waitXfers(int n, int budget, string name, output bit ok);
    int b;
    b = 0;
    while (xSel.size() < n && b < budget) begin
      tick(1);
      b++;
    end
    total++;
    ok = (xSel.size() >= n);
    if (!ok) begin
      bad++;
      $display("[TB] FAIL %s: transfers got %0d required %0d", name, xSel.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; src_vld = '0; src_data = '0; hold = 1'b0; out_rdy = 1'b1;
    #1;
    total++;
    if ({out_vld, out_data, cur_sel, src_rdy} !== {1'b0, 64'h0, 2'd0, 4'hF}) begin
      bad++;
      $display("[TB] FAIL reset_async: got vld=%b data=%h sel=%0d rdy=%b required 0/0/0/1111",
               out_vld, out_data, cur_sel, src_rdy);
    end
    tick(2);
    rst_n = 1'b1;
    clearLog();
    tick(10);
    total++;
    if (vldHigh !== 0 || src_rdy !== 4'hF) begin
      bad++;
      $display("[TB] FAIL reset_idle: got vldHigh=%0d rdy=%b required 0 / 1111", vldHigh, src_rdy);
    end
  endtask

  task automatic test_single_page();
    int e0;
    doReset();
    modelPage[2] = 64'h0102030405060708;
    src_data[2*64 +: 64] = modelPage[2];
    src_vld = 4'b0100;
    e0 = cyc + 1;
    tick(1);
    src_vld = '0;
    total++;
    if (out_vld !== 1'b0) begin
      bad++;
      $display("[TB] FAIL single_early_vld: got %b required 0", out_vld);
    end
    tick(1);
    total++;
    if ({out_vld, out_data, cur_sel, src_rdy} !== {1'b1, 64'h0102030405060708, 2'd2, 4'b1011}) begin
      bad++;
      $display("[TB] FAIL single_load: got vld=%b data=%h sel=%0d rdy=%b required 1/0102030405060708/2/1011",
               out_vld, out_data, cur_sel, src_rdy);
    end
    tick(40);
    total++;
    if (xSel.size() !== 1 || vldHigh !== 1) begin
      bad++;
      $display("[TB] FAIL single_count: got xfers=%0d vldHigh=%0d required 1/1", xSel.size(), vldHigh);
    end else begin
      total++;
      if (xEdge[0] !== e0 + 2) begin
        bad++;
        $display("[TB] FAIL single_latency: got edge %0d required %0d", xEdge[0], e0 + 2);
      end
    end
  endtask

  task automatic test_rotation(input logic [NS-1:0] mask);
    int e0, sel;
    bit ok;
    doReset();
    applyStimulus(mask, e0);
    waitXfers(5, 80, "rotation_wait", ok);
    if (!ok) return;
    sel = lowestIdx(mask);
    for (int k = 0; k < 5; k++) begin
      total++;
      if (xSel[k] !== sel || xData[k] !== modelPage[sel] || xEdge[k] !== e0 + 2 + k * PERIOD) begin
        bad++;
        $display("[TB] FAIL rotation[%0d] mask=%b: got sel=%0d data=%h edge=%0d required sel=%0d data=%h edge=%0d",
                 k, mask, xSel[k], xData[k], xEdge[k], sel, modelPage[sel], e0 + 2 + k * PERIOD);
      end
      sel = nextValid(sel, mask);
    end
  endtask

  task automatic test_refresh();
    int e0, x, w;
    bit ok;
    doReset();
    applyStimulus(4'b0011, e0);
    x = e0 + 2 + PERIOD;
    waitCyc(x + 3);
    modelPage[1] = rnd64();
    src_data[64 +: 64] = modelPage[1];
    src_vld = 4'b0010;
    w = cyc + 1;
    tick(1);
    src_vld = '0;
    waitXfers(4, 60, "refresh_wait", ok);
    if (!ok) return;
    total++;
    if (xSel[2] !== 1 || xData[2] !== modelPage[1] || xEdge[2] !== w + 2) begin
      bad++;
      $display("[TB] FAIL refresh_xfer: got sel=%0d data=%h edge=%0d required sel=1 data=%h edge=%0d",
               xSel[2], xData[2], xEdge[2], modelPage[1], w + 2);
    end
    total++;
    if (xSel[3] !== 0 || xData[3] !== modelPage[0] || xEdge[3] !== x + PERIOD + 2) begin
      bad++;
      $display("[TB] FAIL refresh_rotate: got sel=%0d edge=%0d required sel=0 edge=%0d",
               xSel[3], xEdge[3], x + PERIOD + 2);
    end
  endtask

  task automatic test_stall();
    int e0, x;
    logic [63:0] pageA, pageB, pageC;
    bit ok;
    doReset();
    out_rdy = 1'b0;
    applyStimulus(4'b0001, e0);
    pageA = modelPage[0];
    waitCyc(e0 + 1);
    pageB = rnd64();
    pageC = rnd64();
    src_data[0 +: 64]    = pageB;
    src_data[3*64 +: 64] = pageC;
    src_vld = 4'b1001;
    tick(1);
    src_vld = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      total++;
      if ({out_vld, out_data, cur_sel, src_rdy} !== {1'b1, pageA, 2'd0, 4'b1110}) begin
        bad++;
        $display("[TB] FAIL stall[%0d]: got vld=%b data=%h sel=%0d rdy=%b required 1/%h/0/1110",
                 i, out_vld, out_data, cur_sel, src_rdy, pageA);
      end
      tick(1);
    end
    out_rdy = 1'b1;
    x = cyc + 1;
    tick(2);
    src_vld = '0;
    waitXfers(3, 40, "stall_wait", ok);
    if (!ok) return;
    total++;
    if (xData[0] !== pageA || xEdge[0] !== x) begin
      bad++;
      $display("[TB] FAIL stall_first: got data=%h edge=%0d required %h/%0d", xData[0], xEdge[0], pageA, x);
    end
    total++;
    if (xSel[1] !== 0 || xData[1] !== pageB || xEdge[1] !== x + 3) begin
      bad++;
      $display("[TB] FAIL stall_late_write: got sel=%0d data=%h edge=%0d required 0/%h/%0d",
               xSel[1], xData[1], xEdge[1], pageB, x + 3);
    end
    total++;
    if (xSel[2] !== 3 || xData[2] !== pageC || xEdge[2] !== x + 3 + 7 + 2) begin
      bad++;
      $display("[TB] FAIL stall_other_src: got sel=%0d data=%h edge=%0d required 3/%h/%0d",
               xSel[2], xData[2], xEdge[2], pageC, x + 12);
    end
  endtask

  task automatic test_hold();
    int e0, x, w;
    bit ok;
    doReset();
    applyStimulus(4'b0011, e0);
    x = e0 + 2;
    w = 0;
    waitCyc(x);
    hold = 1'b1;
    for (int i = 0; i < 50; i++) begin
      total++;
      if (cur_sel !== 2'd0) begin
        bad++;
        $display("[TB] FAIL hold_sel[%0d]: got %0d required 0", i, cur_sel);
      end
      if (i == 20) begin
        modelPage[0] = rnd64();
        src_data[0 +: 64] = modelPage[0];
        src_vld = 4'b0001;
        w = cyc + 1;
      end
      if (i == 21) src_vld = '0;
      tick(1);
    end
    hold = 1'b0;
    total++;
    if (xSel.size() !== 2) begin
      bad++;
      $display("[TB] FAIL hold_xfers: got %0d required 2", xSel.size());
      return;
    end
    total++;
    if (xSel[1] !== 0 || xData[1] !== modelPage[0] || xEdge[1] !== w + 2) begin
      bad++;
      $display("[TB] FAIL hold_refresh: got sel=%0d data=%h edge=%0d required 0/%h/%0d",
               xSel[1], xData[1], xEdge[1], modelPage[0], w + 2);
    end
    waitXfers(3, 30, "hold_release_wait", ok);
    if (!ok) return;
    total++;
    if (xSel[2] !== 1 || xData[2] !== modelPage[1] || xEdge[2] !== x + 50 + PERIOD) begin
      bad++;
      $display("[TB] FAIL hold_release: got sel=%0d edge=%0d required 1/%0d",
               xSel[2], xEdge[2], x + 50 + PERIOD);
    end
  endtask

  task automatic test_reset_mid_load();
    int e0;
    bit ok;
    doReset();
    out_rdy = 1'b0;
    applyStimulus(4'b0010, e0);
    waitCyc(e0 + 1);
    total++;
    if (out_vld !== 1'b1) begin
      bad++;
      $display("[TB] FAIL midload_setup: got vld=%b required 1", out_vld);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out_vld, out_data, cur_sel, src_rdy} !== {1'b0, 64'h0, 2'd0, 4'hF}) begin
      bad++;
      $display("[TB] FAIL midload_reset: got vld=%b data=%h sel=%0d rdy=%b required 0/0/0/1111",
               out_vld, out_data, cur_sel, src_rdy);
    end
    tick(2);
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    clearLog();
    for (int i = 0; i < NS; i++) modelPage[i] = '0;
    tick(30);
    total++;
    if (vldHigh !== 0 || xSel.size() !== 0) begin
      bad++;
      $display("[TB] FAIL midload_quiet: got vldHigh=%0d xfers=%0d required 0/0", vldHigh, xSel.size());
    end
    applyStimulus(4'b1000, e0);
    waitXfers(1, 10, "midload_new_wait", ok);
    if (!ok) return;
    total++;
    if (xSel[0] !== 3 || xData[0] !== modelPage[3] || xEdge[0] !== e0 + 2) begin
      bad++;
      $display("[TB] FAIL midload_new: got sel=%0d data=%h edge=%0d required 3/%h/%0d",
               xSel[0], xData[0], xEdge[0], modelPage[3], e0 + 2);
    end
  endtask

  task automatic checkOutput();
    $display("test done: total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    logic [NS-1:0] m;
    test_reset();
    test_single_page();
    test_rotation(4'b1011);
    for (int r = 0; r < 3; r++) begin
      m = NS'($urandom_range(1, 15));
      while ($countones(m) < 2) m = NS'($urandom_range(1, 15));
      test_rotation(m);
    end
    test_refresh();
    test_stall();
    test_hold();
    test_reset_mid_load();
    checkOutput();
    $finish;
  end

endmodule
